// File: rtl/sync_fifo_fc.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// optional first-word-fall-through read, synchronous flush and sticky error flags.
module sync_fifo_fc #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = (1 << ASIZE) - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  input  logic             flush,
  input  logic             err_clr,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_C   = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AFULL_C   = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] AEMPTY_C  = (ASIZE+1)'(AEMPTY_TH);
  localparam logic [ASIZE:0] CNT_ONE   = (ASIZE+1)'(1);
  localparam logic [ASIZE-1:0] PTR_ONE = ASIZE'(1);

  if (!(AEMPTY_TH > 0 && AEMPTY_TH < AFULL_TH && AFULL_TH <= DEPTH)) begin : g_bad_params
    $error("sync_fifo_fc: thresholds must satisfy 0 < AEMPTY_TH < AFULL_TH <= 2**ASIZE");
  end

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [ASIZE-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ASIZE:0]   count_q, count_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             wr_acc_s, rd_acc_s;

  // Every flag decodes from the count register, so request inputs never reach a flag.
  assign wfull         = (count_q == DEPTH_C);
  assign rempty        = (count_q == '0);
  assign walmost_full  = (count_q >= AFULL_C);
  assign ralmost_empty = (count_q <= AEMPTY_C);
  assign count         = count_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;

  assign wr_acc_s = winc && !wfull && !flush;
  assign rd_acc_s = rinc && !rempty && !flush;

  // Next-state pointers, occupancy and sticky errors; a new error beats err_clr.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = (ovf_q && !err_clr) || (winc && wfull && !flush);
    udf_d   = (udf_q && !err_clr) || (rinc && rempty && !flush);
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
      if (rd_acc_s) begin
        rptr_d = rptr_q + PTR_ONE;
      end else begin
        rptr_d = rptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign rdata = mem_q[rptr_q];
  end else begin : g_std
    logic [DSIZE-1:0] rdata_q;

    // Registered read port: loads the head word on an accepted pop, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
      end else if (rd_acc_s) begin
        rdata_q <= mem_q[rptr_q];
      end
    end

    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo_fc.sv
// Bench for sync_fifo_fc: a standard-read and an FWFT instance share stimulus and are
// compared against a queue-based model of the FIFO.
module tb_sync_fifo_fc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       winc = 1'b0, rinc = 1'b0, flush = 1'b0, err_clr = 1'b0;
  logic [7:0] wdata = 8'd0;

  logic [7:0] rdata_s, rdata_f;
  logic       wfull_s, rempty_s, af_s, ae_s, ovf_s, udf_s;
  logic       wfull_f, rempty_f, af_f, ae_f, ovf_f, udf_f;
  logic [4:0] count_s, count_f;

  sync_fifo_fc #(.DSIZE(8), .ASIZE(4), .FWFT(0)) dut_std (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
    .flush(flush), .err_clr(err_clr), .rdata(rdata_s), .wfull(wfull_s),
    .rempty(rempty_s), .walmost_full(af_s), .ralmost_empty(ae_s),
    .count(count_s), .overflow(ovf_s), .underflow(udf_s)
  );

  sync_fifo_fc #(.DSIZE(8), .ASIZE(4), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
    .flush(flush), .err_clr(err_clr), .rdata(rdata_f), .wfull(wfull_f),
    .rempty(rempty_f), .walmost_full(af_f), .ralmost_empty(ae_f),
    .count(count_f), .overflow(ovf_f), .underflow(udf_f)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q[$];
  logic [7:0] m_rdata = 8'd0;
  logic       m_ov = 1'b0, m_un = 1'b0;

  // Drive one cycle of requests and advance the queue model across the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic f, input logic e);
    bit full, empty;
    winc = w; wdata = d; rinc = r; flush = f; err_clr = e;
    @(posedge clk);
    full  = (q.size() == 16);
    empty = (q.size() == 0);
    m_ov = (m_ov && !e) || (w && full && !f);
    m_un = (m_un && !e) || (r && empty && !f);
    if (f) begin
      q.delete();
    end else begin
      if (r && !empty) m_rdata = q.pop_front();
      if (w && !full) q.push_back(d);
    end
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_rdata = 8'd0;
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if (count_s !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_s); end
    n_checks++; if (rempty_s !== 1'b1) begin n_fail++; $display("FAIL reset_rempty: got %b want 1", rempty_s); end
    n_checks++; if (wfull_s !== 1'b0) begin n_fail++; $display("FAIL reset_wfull: got %b want 0", wfull_s); end
    n_checks++; if (af_s !== 1'b0) begin n_fail++; $display("FAIL reset_afull: got %b want 0", af_s); end
    n_checks++; if (ae_s !== 1'b1) begin n_fail++; $display("FAIL reset_aempty: got %b want 1", ae_s); end
    n_checks++; if (ovf_s !== 1'b0 || udf_s !== 1'b0) begin n_fail++; $display("FAIL reset_err: got ov=%b un=%b want 0 0", ovf_s, udf_s); end
    n_checks++; if (rdata_s !== 8'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", rdata_s); end
    n_checks++; if (rempty_f !== 1'b1) begin n_fail++; $display("FAIL reset_fwft_rempty: got %b want 1", rempty_f); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      n_checks++; if (count_s !== 5'(i)) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", count_s, i); end
      n_checks++; if (wfull_s !== (i == 16)) begin n_fail++; $display("FAIL fill_wfull: got %b at count %0d", wfull_s, i); end
      n_checks++; if (af_s !== (i >= 14)) begin n_fail++; $display("FAIL fill_afull: got %b at count %0d", af_s, i); end
      n_checks++; if (ae_s !== (i <= 2)) begin n_fail++; $display("FAIL fill_aempty: got %b at count %0d", ae_s, i); end
      n_checks++; if (rempty_s !== 1'b0) begin n_fail++; $display("FAIL fill_rempty: got %b want 0", rempty_s); end
    end
    step(1'b1, 8'd17, 1'b0, 1'b0, 1'b0);
    n_checks++; if (ovf_s !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b want 1", ovf_s); end
    n_checks++; if (count_s !== 5'd16) begin n_fail++; $display("FAIL overflow_count: got %0d want 16", count_s); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 17; i++) begin
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
      n_checks++; if (rdata_s !== m_rdata) begin n_fail++; $display("FAIL drain_rdata: got %0d want %0d", rdata_s, m_rdata); end
      n_checks++; if (rempty_s !== (i >= 16)) begin n_fail++; $display("FAIL drain_rempty: got %b after read %0d", rempty_s, i); end
    end
    n_checks++; if (udf_s !== 1'b1) begin n_fail++; $display("FAIL underflow_set: got %b want 1", udf_s); end
    n_checks++; if (rdata_s !== 8'd16) begin n_fail++; $display("FAIL underflow_rdata_hold: got %0d want 16", rdata_s); end
  endtask

  task automatic test_err_clr();
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (ovf_s !== 1'b0 || udf_s !== 1'b0) begin n_fail++; $display("FAIL err_clr: got ov=%b un=%b want 0 0", ovf_s, udf_s); end
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
    n_checks++; if (udf_s !== 1'b1) begin n_fail++; $display("FAIL err_clr_vs_new_error: got %b want 1", udf_s); end
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) step(1'b1, 8'(50 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
      n_checks++; if (rdata_s !== m_rdata) begin n_fail++; $display("FAIL wrap_pre_rdata: got %0d want %0d", rdata_s, m_rdata); end
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(100 + i), 1'b1, 1'b0, 1'b0);
      n_checks++; if (rdata_s !== m_rdata) begin n_fail++; $display("FAIL wrap_rdata: got %0d want %0d", rdata_s, m_rdata); end
      n_checks++; if (count_s !== 5'(q.size())) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", count_s, q.size()); end
      if (q.size() != 0) begin
        n_checks++; if (rdata_f !== q[0]) begin n_fail++; $display("FAIL wrap_fwft_head: got %0d want %0d", rdata_f, q[0]); end
      end
    end
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
    n_checks++; if (rdata_s !== 8'd119) begin n_fail++; $display("FAIL wrap_last: got %0d want 119", rdata_s); end
  endtask

  task automatic test_boundary();
    step(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(200 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    n_checks++; if (count_s !== 5'd15) begin n_fail++; $display("FAIL full_simul_count: got %0d want 15", count_s); end
    n_checks++; if (ovf_s !== 1'b1) begin n_fail++; $display("FAIL full_simul_overflow: got %b want 1", ovf_s); end
    n_checks++; if (rdata_s !== 8'd200) begin n_fail++; $display("FAIL full_simul_rdata: got %0d want 200", rdata_s); end
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    n_checks++; if (count_s !== 5'd1) begin n_fail++; $display("FAIL empty_simul_count: got %0d want 1", count_s); end
    n_checks++; if (udf_s !== 1'b1) begin n_fail++; $display("FAIL empty_simul_underflow: got %b want 1", udf_s); end
    n_checks++; if (rdata_f !== 8'h33) begin n_fail++; $display("FAIL empty_simul_fwft: got %h want 33", rdata_f); end
  endtask

  task automatic test_fwft();
    step(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    n_checks++; if (rempty_f !== 1'b0) begin n_fail++; $display("FAIL fwft_rempty: got %b want 0", rempty_f); end
    n_checks++; if (rdata_f !== 8'hA5) begin n_fail++; $display("FAIL fwft_first: got %h want a5", rdata_f); end
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    n_checks++; if (rdata_f !== 8'hA5) begin n_fail++; $display("FAIL fwft_hold: got %h want a5", rdata_f); end
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (rdata_f !== 8'h5A) begin n_fail++; $display("FAIL fwft_pop: got %h want 5a", rdata_f); end
    n_checks++; if (rdata_s !== 8'hA5) begin n_fail++; $display("FAIL fwft_std_pop: got %h want a5", rdata_s); end
  endtask

  task automatic test_flush();
    step(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 8'(10 + i), 1'b0, 1'b0, 1'b0);
    n_checks++; if (count_s !== 5'd7) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 7", count_s); end
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    n_checks++; if (count_s !== 5'd0 || rempty_s !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got count=%0d rempty=%b want 0 1", count_s, rempty_s); end
    n_checks++; if (udf_s !== 1'b1 || ovf_s !== 1'b0) begin n_fail++; $display("FAIL flush_sticky: got ov=%b un=%b want 0 1", ovf_s, udf_s); end
    n_checks++; if (rdata_s !== 8'hA5) begin n_fail++; $display("FAIL flush_rdata_hold: got %h want a5", rdata_s); end
    step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (rdata_s !== 8'h42 || count_s !== 5'd0) begin n_fail++; $display("FAIL flush_dropped: got rdata=%h count=%0d want 42 0", rdata_s, count_s); end
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (udf_s !== 1'b0) begin n_fail++; $display("FAIL flush_err_clr: got %b want 0", udf_s); end
  endtask

  task automatic test_random();
    int wp;
    for (int i = 0; i < 600; i++) begin
      wp = (i < 200) ? 75 : ((i < 400) ? 25 : 50);
      step(($urandom_range(0, 99) < wp), 8'($urandom), ($urandom_range(0, 99) >= wp),
           ($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0));
      n_checks++; if (count_s !== 5'(q.size())) begin n_fail++; $display("FAIL rand_count: cyc %0d got %0d want %0d", i, count_s, q.size()); end
      n_checks++; if ({wfull_s, rempty_s} !== {q.size() == 16, q.size() == 0}) begin n_fail++; $display("FAIL rand_full_empty: cyc %0d got %b%b size %0d", i, wfull_s, rempty_s, q.size()); end
      n_checks++; if ({af_s, ae_s} !== {q.size() >= 14, q.size() <= 2}) begin n_fail++; $display("FAIL rand_almost: cyc %0d got %b%b size %0d", i, af_s, ae_s, q.size()); end
      n_checks++; if ({ovf_s, udf_s} !== {m_ov, m_un}) begin n_fail++; $display("FAIL rand_err: cyc %0d got %b%b want %b%b", i, ovf_s, udf_s, m_ov, m_un); end
      n_checks++; if (rdata_s !== m_rdata) begin n_fail++; $display("FAIL rand_rdata: cyc %0d got %h want %h", i, rdata_s, m_rdata); end
      if (q.size() != 0) begin
        n_checks++; if (rdata_f !== q[0]) begin n_fail++; $display("FAIL rand_fwft: cyc %0d got %h want %h", i, rdata_f, q[0]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(60 + i), (i > 2), 1'b0, 1'b0);
    step(1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
    winc = 1'b1; rinc = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if (count_s !== 5'd0 || rempty_s !== 1'b1 || wfull_s !== 1'b0) begin n_fail++; $display("FAIL midreset_count: got count=%0d rempty=%b wfull=%b", count_s, rempty_s, wfull_s); end
    n_checks++; if (af_s !== 1'b0 || ae_s !== 1'b1) begin n_fail++; $display("FAIL midreset_almost: got af=%b ae=%b want 0 1", af_s, ae_s); end
    n_checks++; if (ovf_s !== 1'b0 || udf_s !== 1'b0) begin n_fail++; $display("FAIL midreset_err: got ov=%b un=%b want 0 0", ovf_s, udf_s); end
    n_checks++; if (rdata_s !== 8'd0) begin n_fail++; $display("FAIL midreset_rdata: got %h want 00", rdata_s); end
    winc = 1'b0; rinc = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (rdata_s !== 8'h99 || count_s !== 5'd0) begin n_fail++; $display("FAIL postreset_rw: got rdata=%h count=%0d want 99 0", rdata_s, count_s); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_err_clr();
    test_wrap();
    test_boundary();
    test_fwft();
    test_flush();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
